// File: rtl/aes_key_sched_ctrl.sv
// AES-128 round-key expansion sequencer: drives an external round-function unit and
// keeps NR+1 round keys for the cipher. AES_KEY_SCHED_CNT_EN adds a completed-expansion counter.
module aes_key_sched_ctrl #(
  parameter int unsigned NR    = 10,
  parameter int unsigned KEY_W = 128,
  parameter int unsigned CNT_W = 16
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_load,
  input  logic             dp_busy,
  output logic             rf_req_valid,
  input  logic             rf_req_ready,
  output logic [KEY_W-1:0] rf_key,
  output logic [7:0]       rf_rcon,
  input  logic             rf_rsp_valid,
  input  logic [KEY_W-1:0] rf_rsp_key,
  input  logic [3:0]       rk_rd_addr,
  output logic [KEY_W-1:0] rk_rd_data,
  output logic             keys_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] exp_cnt
);

  localparam logic [3:0] NrIdx = 4'(NR);

  typedef enum logic [2:0] {
    StIdle, StWaitDp, StLoad, StReq, StRsp, StDrain, StDone
  } state_e;

  state_e           state_q, state_d, restart_st;
  logic [KEY_W-1:0] key_hold_q, key_hold_d;
  logic [KEY_W-1:0] prev_q, prev_d;
  logic [7:0]       rcon_q, rcon_d;
  logic [3:0]       r_q, r_d;
  logic             pending_q, pending_d;
  logic             keys_valid_q, keys_valid_d;
  logic             done_q, done_d;
  logic             rk_we;
  logic [3:0]       rk_waddr;
  logic [KEY_W-1:0] rk_wdata;
  logic [KEY_W-1:0] rk_q [NR+1];
  logic [KEY_W-1:0] rd_data_q;

  assign restart_st = dp_busy ? StWaitDp : StLoad;

  always_comb begin
    state_d      = state_q;
    key_hold_d   = key_hold_q;
    prev_d       = prev_q;
    rcon_d       = rcon_q;
    r_d          = r_q;
    pending_d    = pending_q;
    keys_valid_d = keys_valid_q;
    done_d       = 1'b0;
    rk_we        = 1'b0;
    rk_waddr     = r_q;
    rk_wdata     = rf_rsp_key;
    if (key_load) key_hold_d = key_in;
    unique case (state_q)
      StIdle:   if (key_load) state_d = restart_st;
      StWaitDp: if (!dp_busy) state_d = StLoad;
      StLoad: begin
        // A commit landing in this very cycle is the newest key, so it wins here too.
        rk_we     = 1'b1;
        rk_waddr  = '0;
        rk_wdata  = key_load ? key_in : key_hold_q;
        prev_d    = rk_wdata;
        rcon_d    = 8'h01;
        r_d       = 4'd1;
        pending_d = 1'b0;
        state_d   = StReq;
      end
      StReq: begin
        if (key_load) pending_d = 1'b1;
        if (rf_req_ready) state_d = (pending_q || key_load) ? StDrain : StRsp;
      end
      StRsp: begin
        if (key_load) begin
          // A response arriving together with the commit is the outstanding one: drop it.
          state_d = rf_rsp_valid ? restart_st : StDrain;
        end else if (rf_rsp_valid) begin
          rk_we  = 1'b1;
          prev_d = rf_rsp_key;
          rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1B : 8'h00);
          if (r_q == NrIdx) begin
            state_d      = StDone;
            done_d       = 1'b1;
            keys_valid_d = 1'b1;
          end else begin
            r_d     = r_q + 4'd1;
            state_d = StReq;
          end
        end
      end
      StDrain: begin
        if (rf_rsp_valid) begin
          pending_d = 1'b0;
          state_d   = restart_st;
        end
      end
      StDone:  state_d = key_load ? restart_st : StIdle;
      default: state_d = StIdle;
    endcase
    if (state_d == StLoad) keys_valid_d = 1'b0;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q      <= StIdle;
      key_hold_q   <= '0;
      prev_q       <= '0;
      rcon_q       <= 8'h01;
      r_q          <= '0;
      pending_q    <= 1'b0;
      keys_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_hold_q   <= key_hold_d;
      prev_q       <= prev_d;
      rcon_q       <= rcon_d;
      r_q          <= r_d;
      pending_q    <= pending_d;
      keys_valid_q <= keys_valid_d;
      done_q       <= done_d;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int unsigned i = 0; i < NR + 1; i++) rk_q[i] <= '0;
      rd_data_q <= '0;
    end else begin
      if (rk_we) rk_q[rk_waddr] <= rk_wdata;
      rd_data_q <= (rk_rd_addr <= NrIdx) ? rk_q[rk_rd_addr] : '0;
    end
  end

  assign rf_req_valid = (state_q == StReq);
  assign rf_key       = rf_req_valid ? prev_q : '0;
  assign rf_rcon      = rf_req_valid ? rcon_q : 8'h00;
  assign rk_rd_data   = rd_data_q;
  assign keys_valid   = keys_valid_q;
  assign busy         = (state_q != StIdle);
  assign done         = done_q;

`ifdef AES_KEY_SCHED_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cnt_q <= '0;
    end else if (done_q && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign exp_cnt = cnt_q;
`else
  assign exp_cnt = '0;
`endif

endmodule
